// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-2 working/digest register bank.
package sha_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_FINAL = 2'd2;

  // Default rounds per word width
  localparam int unsigned ROUNDS_256 = 64;
  localparam int unsigned ROUNDS_512 = 80;

  // Initial hash values, H0 in the MSBs
  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [511:0] SHA512_IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  // Rounds per block for a given word width
  function automatic int unsigned default_rounds(input int unsigned width);
    return (width == 64) ? ROUNDS_512 : ROUNDS_256;
  endfunction

endpackage

// File: rtl/sha_word_reg.sv
// Single WIDTH-bit load-enable register, async active-high clear.
module sha_word_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // Load when enabled, otherwise hold
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)       q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/sha_state_regbank.sv
// SHA-2 working variables A..H and chaining words H0..H7 with block sequencing.
// Optional synchronous clear input zeroize_i under macro SHA_STATE_ZEROIZE_EN.
module sha_state_regbank
  import sha_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned ROUNDS = default_rounds(WIDTH),
  localparam int unsigned RW     = $clog2(ROUNDS)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start_i,
  input  logic               first_i,
  input  logic [8*WIDTH-1:0] iv_i,
  input  logic               round_valid_i,
  input  logic [WIDTH-1:0]   t1_i,
  input  logic [WIDTH-1:0]   t2_i,
`ifdef SHA_STATE_ZEROIZE_EN
  input  logic               zeroize_i,
`endif
  output logic [8*WIDTH-1:0] work_o,
  output logic [8*WIDTH-1:0] digest_o,
  output logic [RW-1:0]      round_o,
  output logic               busy_o,
  output logic               done_o
);

  logic [WIDTH-1:0] work_q [8];
  logic [WIDTH-1:0] work_d [8];
  logic [WIDTH-1:0] dig_q  [8];
  logic [WIDTH-1:0] dig_d  [8];
  logic             work_en;
  logic             dig_en;

  state_t           state_q, state_d;
  logic [RW-1:0]    round_q, round_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_round;

  assign last_round = (round_q == RW'(ROUNDS - 1));

  // Next-state, next-word muxing and modular adders
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    work_en = 1'b0;
    dig_en  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      work_d[k] = work_q[k];
      dig_d[k]  = dig_q[k];
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          work_en = 1'b1;
          round_d = '0;
          state_d = ST_RUN;
          if (first_i) begin
            // A new message seeds the chaining value too, so FINAL adds onto the IV
            dig_en = 1'b1;
            for (int k = 0; k < 8; k++) begin
              work_d[k] = iv_i[(7-k)*WIDTH +: WIDTH];
              dig_d[k]  = iv_i[(7-k)*WIDTH +: WIDTH];
            end
          end else begin
            for (int k = 0; k < 8; k++) work_d[k] = dig_q[k];
          end
        end
      end
      ST_RUN: begin
        if (round_valid_i) begin
          work_en = 1'b1;
          for (int k = 1; k < 8; k++) work_d[k] = work_q[k-1];
          work_d[4] = work_q[3] + t1_i;
          work_d[0] = t1_i + t2_i;
          if (last_round) begin
            round_d = '0;
            state_d = ST_FINAL;
          end else begin
            round_d = round_q + RW'(1);
          end
        end
      end
      ST_FINAL: begin
        dig_en = 1'b1;
        for (int k = 0; k < 8; k++) dig_d[k] = dig_q[k] + work_q[k];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_FINAL);

`ifdef SHA_STATE_ZEROIZE_EN
    if (zeroize_i) begin
      work_en = 1'b1;
      dig_en  = 1'b1;
      for (int k = 0; k < 8; k++) begin
        work_d[k] = '0;
        dig_d[k]  = '0;
      end
      round_d = '0;
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
`endif
  end

  // Sixteen word registers and output packing (word 0 in the MSBs)
  for (genvar k = 0; k < 8; k++) begin : g_words
    sha_word_reg #(.WIDTH(WIDTH)) u_work (
      .CLK  (CLK),
      .RST  (RST),
      .en_i (work_en),
      .d_i  (work_d[k]),
      .q_o  (work_q[k])
    );
    sha_word_reg #(.WIDTH(WIDTH)) u_dig (
      .CLK  (CLK),
      .RST  (RST),
      .en_i (dig_en),
      .d_i  (dig_d[k]),
      .q_o  (dig_q[k])
    );
    assign work_o[(7-k)*WIDTH +: WIDTH]   = work_q[k];
    assign digest_o[(7-k)*WIDTH +: WIDTH] = dig_q[k];
  end

  // Control state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign round_o = round_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: doc/sha_state_regbank.md
Name: sha_state_regbank

Overview:
Parametrised working-variable and digest register bank for the SHA-2 compression core. Holds the eight working words A..H and the eight chaining words H0..H7, each in its own load-enable register. Sequences one compression block: load from IV or chaining value, shift through ROUNDS rounds using externally computed T1/T2, then accumulate into the digest. Sits between the message scheduler / round-function datapath and the top-level controller.

Parameters:
WIDTH, 32, word width in bits; 32 = SHA-224/256, 64 = SHA-384/512
ROUNDS, 64, rounds per block; 64 for WIDTH=32, 80 for WIDTH=64
RW, $clog2(ROUNDS), round counter width (derived, not overridden)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
start_i  in  1  begin a block; sampled only in IDLE
first_i  in  1  with start_i: 1 = load IV, 0 = load current digest
iv_i  in  8*WIDTH  initial hash value, H0 in MSBs
round_valid_i  in  1  T1/T2 valid for current round
t1_i  in  WIDTH  T1 for current round
t2_i  in  WIDTH  T2 for current round
work_o  out  8*WIDTH  A..H, A in MSBs
digest_o  out  8*WIDTH  H0..H7, H0 in MSBs
round_o  out  RW  index of round being consumed
busy_o  out  1  high in LOAD/RUN/FINAL
done_o  out  1  one-cycle pulse: digest_o updated

Behaviour:
- Reset (RST=1, async): all work/digest words 0, round_o=0, busy_o=0, done_o=0, state IDLE. Applies mid-block; the block is discarded.
- FSM states: IDLE, RUN, FINAL.
- IDLE: start_i=1 -> next cycle A..H = iv_i words (first_i=1) or digest words (first_i=0); round_o=0; busy_o=1; state RUN. start_i=0 -> all registers hold.
- RUN: round_valid_i=0 -> hold everything (stall, no limit). round_valid_i=1 -> H<=G, G<=F, F<=E, E<=D+t1_i, D<=C, C<=B, B<=A, A<=t1_i+t2_i; round_o += 1. When round_o==ROUNDS-1 with round_valid_i=1: shift, round_o<=0, state FINAL.
- FINAL (exactly one cycle, unconditional): Hk <= Hk + work word k for k=0..7; state IDLE; done_o=1 in the following cycle (digest_o already updated); busy_o=0 in that cycle.
- Arithmetic: all additions modulo 2^WIDTH, carry discarded.
- start_i outside IDLE: ignored, no error. start_i in the cycle done_o=1 (IDLE): accepted, so back-to-back blocks are legal.
- round_valid_i outside RUN: ignored.
- Latency start->done_o with round_valid_i held high: ROUNDS+2 cycles.
- done_o is a registered, one-cycle pulse; all outputs registered.

Optional Feature:
Macro SHA_STATE_ZEROIZE_EN.
- Defined: adds input zeroize_i (1 bit). Synchronous; when 1, next cycle all work/digest words=0, round_o=0, state IDLE, done_o=0. Priority: RST > zeroize_i > all else.
- Not defined: port absent; registers cleared only by RST.

Decomposition:
- Package sha_pkg: FSM state enum; SHA-256 and SHA-512 IV constants (top level drives iv_i from them); default ROUNDS per width.
- Sub-module sha_word_reg: parametrised WIDTH load-enable register, async active-high reset to 0; 16 instances (8 work, 8 digest). Next-value muxing and adders stay in sha_state_regbank.

Test Plan:
- Reset mid-RUN at round 17 -> all outputs 0, state IDLE, busy_o=0; a fresh start_i afterwards runs normally.
- WIDTH=32, single block "abc", T1/T2 from golden model, round_valid_i held 1 -> done_o exactly 66 cycles after start_i; digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same block with round_valid_i randomly low 50% of cycles -> identical digest; round_o and work_o frozen on each stall cycle.
- Two-block message (first_i=1 then first_i=0, second start_i in the done_o cycle) -> matches model; start_i pulses during RUN ignored.
- Modular wrap: all words 0xFFFFFFFF, t1_i=t2_i=0x00000001 for one round -> A=0x00000002, E=0x00000000.
- WIDTH=64, ROUNDS=80, "abc" -> done_o after 82 cycles; digest_o begins ddaf35a193617aba; with SHA_STATE_ZEROIZE_EN, zeroize_i at round 40 -> all outputs 0 next cycle.
